// File: rtl/uart_transmitter.sv
// uart_transmitter: byte FIFO plus 8-bit serial framer, LSB first, optional parity, 1 or 2 stop bits
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high; clears FIFO and FSM, forces the line high
//   enable     high allows new frames to start
//   in/valid   byte to queue; accepted when valid & ready at a rising edge
//   ready      FIFO has a free entry
//   out        registered serial line, idle high
//   busy       a frame is in progress
//   fifo_count bytes queued, excluding the frame in flight
module uart_transmitter #(
  parameter int CLOCK_RATE = 20000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [7:0]                         in,
  input  logic                               valid,
  output logic                               ready,
  output logic                               out,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH+1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  if (DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_transmitter: unsupported parameter combination");
  end
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [NW-1:0] r_count;
  logic [2:0]    r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_out;
  logic [7:0]    w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_tick;
  logic          w_last_stop;
  logic          w_par;
  always_comb begin
    w_head      = r_mem[r_rd];
    w_push      = valid && ready;
    w_tick      = r_baud == CW'(DIV - 1);
    w_last_stop = r_state == S_STOP && w_tick && r_bit == 3'(STOP_BITS - 1);
    // a pop only ever happens from IDLE or on the final stop-bit tick, giving gapless back-to-back frames
    w_pop       = enable && r_count != '0 && (r_state == S_IDLE || w_last_stop);
    w_par       = PARITY == 2 ? ~^w_head : ^w_head;
  end
  assign ready      = r_count != NW'(FIFO_DEPTH);
  assign busy       = r_state != S_IDLE;
  assign out        = r_out;
  assign fifo_count = r_count;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= in;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + NW'(w_push) - NW'(w_pop);
    end
  end
  // the baud counter restarts at every bit boundary and rests at zero while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_baud <= '0;
    else r_baud <= (r_state == S_IDLE || w_tick) ? '0 : r_baud + CW'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_out   <= 1'b1;
    end else if (w_pop) begin
      r_state <= S_START;
      r_bit   <= '0;
      r_shift <= w_head;
      r_par   <= w_par;
      r_out   <= 1'b0;
    end else begin
      case (r_state)
        S_START: if (w_tick) begin
          r_state <= S_DATA;
          r_bit   <= '0;
          r_out   <= r_shift[0];
        end
        S_DATA: if (w_tick) begin
          if (r_bit == 3'd7) begin
            r_state <= PARITY != 0 ? S_PARITY : S_STOP;
            r_bit   <= '0;
            r_out   <= PARITY != 0 ? r_par : 1'b1;
          end else begin
            r_bit   <= r_bit + 3'd1;
            r_shift <= r_shift >> 1;
            r_out   <= r_shift[1];
          end
        end
        S_PARITY: if (w_tick) begin
          r_state <= S_STOP;
          r_bit   <= '0;
          r_out   <= 1'b1;
        end
        S_STOP: if (w_tick) begin
          r_state <= w_last_stop ? S_IDLE : S_STOP;
          r_bit   <= w_last_stop ? 3'd0 : r_bit + 3'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench for uart_transmitter across four parameter sets
module tb_uart_transmitter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [7:0] din = 8'h00;
  logic [3:0] vld = 4'h0;
  wire [3:0] line;
  wire [3:0] busy;
  wire [3:0] rdy;
  wire [3:0][2:0] cnt;
  typedef struct { int k; int data; int par; } exp_t;
  exp_t sb[$];
  int start_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_transmitter #(.CLOCK_RATE(1000000), .BAUD_RATE(250000), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .in(din), .valid(vld[0]), .ready(rdy[0]),
    .out(line[0]), .busy(busy[0]), .fifo_count(cnt[0]));
  uart_transmitter #(.CLOCK_RATE(1000000), .BAUD_RATE(250000), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .in(din), .valid(vld[1]), .ready(rdy[1]),
    .out(line[1]), .busy(busy[1]), .fifo_count(cnt[1]));
  uart_transmitter #(.CLOCK_RATE(1000000), .BAUD_RATE(250000), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .in(din), .valid(vld[2]), .ready(rdy[2]),
    .out(line[2]), .busy(busy[2]), .fifo_count(cnt[2]));
  uart_transmitter u_d (
    .clk(clk), .reset(reset), .enable(enable), .in(din), .valid(vld[3]), .ready(rdy[3]),
    .out(line[3]), .busy(busy[3]), .fifo_count(cnt[3]));
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int k, input logic [7:0] b);
    din = b;
    vld[k] = 1'b1;
    tick();
    vld[k] = 1'b0;
  endtask
  task automatic wait_idle(input int k, input int bound, input bit use_sb);
    int n = 0;
    while ((busy[k] || (use_sb && sb.size() != 0)) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout dut%0d: still busy after %0d cycles, expected idle", k, n);
    end
  endtask
  task automatic measure_busy(input int k, input int bound, output int n);
    n = 0;
    while (busy[k] && n < bound) begin
      n++;
      tick();
    end
  endtask
  task automatic mon(input int k, input int div, input int has_par, input int stops);
    logic bits [16];
    logic [7:0] d;
    bit stable;
    bit aborted;
    int nb;
    exp_t e;
    nb = 10 + has_par + stops - 1;
    forever begin
      @(negedge line[k]);
      start_q.push_back(cyc);
      stable = 1'b1;
      aborted = 1'b0;
      for (int j = 0; j < nb && !aborted; j++) begin
        for (int c = 0; c < div && !aborted; c++) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
          else if (c == 0) bits[j] = line[k];
          else if (line[k] !== bits[j]) stable = 1'b0;
        end
      end
      if (!aborted) begin
        for (int i = 0; i < 8; i++) d[i] = bits[i+1];
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame dut%0d: got byte 0x%0h, expected no frame", k, d);
        end else begin
          e = sb.pop_front();
          check($sformatf("frame_dut dut%0d", k), k, e.k);
          check($sformatf("start_bit dut%0d", k), int'(bits[0]), 0);
          check($sformatf("data dut%0d", k), int'(d), e.data);
          if (has_par != 0) check($sformatf("parity dut%0d", k), int'(bits[9]), e.par);
          for (int s = 9 + has_par; s < nb; s++) check($sformatf("stop_bit dut%0d", k), int'(bits[s]), 1);
          check($sformatf("bit_width dut%0d", k), int'(stable), 1);
        end
      end
    end
  endtask
  initial begin
    int n;
    int quiet;
    fork
      mon(0, 4, 0, 1);
      mon(1, 4, 1, 2);
      mon(2, 4, 1, 1);
      mon(3, 2083, 0, 1);
    join_none
    repeat (3) tick();
    check("rst_out", int'(line[0]), 1);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_cnt", int'(cnt[0]), 0);
    check("rst_ready", int'(rdy[0]), 1);
    reset = 1'b0;
    enable = 1'b1;
    tick();
    sb.push_back('{0, 'h55, 0});
    push(0, 8'h55);
    check("push_cnt", int'(cnt[0]), 1);
    check("push_out", int'(line[0]), 1);
    tick();
    check("pop_out", int'(line[0]), 0);
    check("pop_busy", int'(busy[0]), 1);
    check("pop_cnt", int'(cnt[0]), 0);
    measure_busy(0, 1000, n);
    check("frame_len_p0s1", n, 40);
    wait_idle(0, 200, 1'b1);
    enable = 1'b0;
    vld[0] = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      din = 8'(b);
      tick();
      if (b == 3) check("ready_at_3", int'(rdy[0]), 1);
      if (b == 4) begin
        check("full_cnt", int'(cnt[0]), 4);
        check("full_ready", int'(rdy[0]), 0);
      end
    end
    vld[0] = 1'b0;
    check("drop_cnt", int'(cnt[0]), 4);
    for (int b = 1; b <= 4; b++) sb.push_back('{0, b, 0});
    start_q.delete();
    enable = 1'b1;
    wait_idle(0, 400, 1'b1);
    repeat (20) tick();
    check("b2b_frames", start_q.size(), 4);
    for (int i = 1; i < start_q.size(); i++) check("b2b_gap", start_q[i] - start_q[i-1], 40);
    check("drained_cnt", int'(cnt[0]), 0);
    sb.push_back('{0, 'hA5, 0});
    sb.push_back('{0, 'h3C, 0});
    push(0, 8'hA5);
    push(0, 8'h3C);
    repeat (5) tick();
    enable = 1'b0;
    wait_idle(0, 200, 1'b0);
    check("gate_out", int'(line[0]), 1);
    check("gate_cnt", int'(cnt[0]), 1);
    repeat (10) tick();
    check("gate_hold_busy", int'(busy[0]), 0);
    check("gate_hold_cnt", int'(cnt[0]), 1);
    enable = 1'b1;
    tick();
    check("regate_busy", int'(busy[0]), 1);
    check("regate_out", int'(line[0]), 0);
    check("regate_cnt", int'(cnt[0]), 0);
    wait_idle(0, 200, 1'b1);
    push(0, 8'hF0);
    push(0, 8'h0F);
    push(0, 8'h33);
    check("rstmid_cnt_before", int'(cnt[0]), 2);
    repeat (16) tick();
    check("rstmid_bit3_out", int'(line[0]), 0);
    #2 reset = 1'b1;
    #1;
    check("rstmid_out", int'(line[0]), 1);
    check("rstmid_busy", int'(busy[0]), 0);
    check("rstmid_cnt", int'(cnt[0]), 0);
    check("rstmid_ready", int'(rdy[0]), 1);
    tick();
    tick();
    reset = 1'b0;
    quiet = 0;
    repeat (60) begin
      tick();
      if (busy[0] || !line[0]) quiet++;
    end
    check("rstmid_no_resume", quiet, 0);
    sb.push_back('{0, 'h81, 0});
    push(0, 8'h81);
    wait_idle(0, 200, 1'b1);
    sb.push_back('{1, 'h07, 1});
    push(1, 8'h07);
    tick();
    measure_busy(1, 1000, n);
    check("frame_len_even_s2", n, 48);
    wait_idle(1, 200, 1'b1);
    sb.push_back('{1, 'h03, 0});
    push(1, 8'h03);
    wait_idle(1, 200, 1'b1);
    sb.push_back('{2, 'h07, 0});
    push(2, 8'h07);
    tick();
    measure_busy(2, 1000, n);
    check("frame_len_odd_s1", n, 44);
    wait_idle(2, 200, 1'b1);
    sb.push_back('{2, 'h06, 1});
    push(2, 8'h06);
    wait_idle(2, 200, 1'b1);
    sb.push_back('{3, 'h41, 0});
    push(3, 8'h41);
    tick();
    measure_busy(3, 30000, n);
    check("frame_len_default", n, 20830);
    wait_idle(3, 3000, 1'b1);
    repeat (10) tick();
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter, the transmit-side counterpart of the charmatrix UART receiver. Accepts bytes over a valid/ready handshake into a small FIFO and serialises them as 8-bit frames, LSB first, with optional parity and 1 or 2 stop bits. A fixed integer baud divider derived from the system clock sets the bit rate. It provides the return path for status and echo traffic from the LED character-matrix design.

## Interface
- CLOCK_RATE, 20000000: system clock frequency in Hz.
- BAUD_RATE, 9600: bit rate; bit period DIV = CLOCK_RATE / BAUD_RATE (integer truncation, 2083 at defaults); DIV ≥ 2 required.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, ≥ 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears FIFO and FSM.
- enable  in  1  high allows new frames to start.
- in  in  8  byte to transmit.
- valid  in  1  `in` is valid.
- ready  out  1  FIFO can accept a byte.
- out  out  1  serial TX line, idle high, registered.
- busy  out  1  a frame is in progress.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  bytes queued, excluding the frame in flight.

One clock; reset is asynchronous and active-high.

## Operation
- Reset values: out=1, busy=0, fifo_count=0, ready=1. FSM is IDLE; baud counter, bit index and FIFO pointers are 0.
- ready = (fifo_count != FIFO_DEPTH), combinational, independent of enable.
- Push: valid & ready at a rising edge writes `in` to the FIFO. valid while ready=0 is ignored; the byte is dropped and no error is flagged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if enable & fifo_count>0, pop head, load shift register, out←0, → START.
  - START: after DIV clocks, out←data[0], → DATA.
  - DATA: 8 bits LSB first, DIV clocks each. After bit 7: → PARITY if PARITY≠0, else out←1 and → STOP.
  - PARITY: bit = ^data (even) or ~^data (odd), held DIV clocks, then out←1, → STOP.
  - STOP: out=1 for STOP_BITS×DIV clocks. At the end, if enable & FIFO non-empty, pop next byte, out←0, → START on the same edge (no idle gap). Otherwise → IDLE.
- Frame length = DIV × (10 + (PARITY≠0) + (STOP_BITS−1)) clocks.
- busy=1 in every state except IDLE.
- Simultaneous push and pop in the same cycle: both happen; fifo_count is unchanged.
- Push into an empty FIFO: the byte becomes visible to the FSM on the next cycle. There is no bypass path.
- Deasserting enable mid-frame lets the current frame finish; no further pop occurs until enable returns.
- Reset mid-frame: out→1 immediately (asynchronous), queued bytes are discarded, and no partial frame resumes.
- `in` is captured into the FIFO at push; changing `in` afterwards has no effect.

## Timing
- Push at edge N with FSM IDLE and enable=1: pop at edge N+1; out falls and busy rises at N+1.
- Each bit is exactly DIV clocks. The baud counter runs 0..DIV−1 and restarts at every bit boundary; it does not free-run across frames.
- fifo_count updates at the push/pop edge. ready falls in the cycle after the push that fills the FIFO.
- Back-to-back frames are contiguous: the next start bit begins exactly one frame length after the previous start bit.

## Test plan
- Byte transfer: CLOCK_RATE=1000000, BAUD_RATE=250000 (DIV=4), PARITY=0, STOP_BITS=1; push 0x55 -> out falls 1 cycle after push and follows 0,1,0,1,0,1,0,1,0,1 (start, data, stop), 4 clocks per bit; busy high 40 clocks.
- Parity and stop bits: PARITY=1 (even), STOP_BITS=2; push 0x07 -> parity bit 1 after data, then 8 clocks high; frame 48 clocks. PARITY=2 (odd) -> parity bit 0.
- FIFO full: push 0x01..0x05 on consecutive cycles, FIFO_DEPTH=4 -> first four accepted, ready=0 when fifo_count=4, 0x05 not transmitted unless re-pushed. Four frames go out back-to-back with no gap, in order 0x01..0x04.
- Enable gating: queue 2 bytes, drop enable during frame 1 -> frame 1 completes, out stays 1, fifo_count=1. Raise enable -> frame 2 starts next cycle.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> out=1, busy=0, fifo_count=0 asynchronously. After release, no frame is emitted until a new push.
- Default params: push 0x41 at CLOCK_RATE=20000000, BAUD_RATE=9600 -> each bit 2083 clocks, frame 20830 clocks.
